// File: rtl/fft_index_counter.sv
// Multi-pass FFT index generator: sweeps 0..max_val-1 once per stage under ce,
// flags the last index of each pass. Optional bit-reverse via FFT_IDX_BITREV_EN.
module fft_index_counter #(
  parameter int unsigned WIDTH   = 12,
  parameter int unsigned STAGE_W = 4,
  parameter int unsigned RB_W    = $clog2(WIDTH) + 1
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic               start,
  input  logic               ce,
  input  logic [WIDTH-1:0]   max_val,
  input  logic [STAGE_W-1:0] n_stages,
  input  logic [RB_W-1:0]    rev_bits,
  output logic [WIDTH-1:0]   o_data,
  output logic [WIDTH-1:0]   o_rev,
  output logic [STAGE_W-1:0] o_stage,
  output logic               over,
  output logic               busy,
  output logic               done
);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StRun  = 1'b1;

  logic [0:0]         state_q, state_d;
  logic [WIDTH-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]   max_q, max_d;
  logic [STAGE_W-1:0] stage_q, stage_d;
  logic [STAGE_W-1:0] nst_q, nst_d;
  logic               done_q, done_d;

  logic               accept;
  logic [WIDTH-1:0]   last;
  logic               at_last;
  logic               final_pass;

  assign accept = (state_q == StIdle) & start & (n_stages != '0);

  // max_val of 0 wraps to all-ones, i.e. a full 2^WIDTH pass.
  assign last       = max_q - WIDTH'(1);
  assign at_last    = (idx_q == last);
  assign final_pass = (stage_q == nst_q - STAGE_W'(1));

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    max_d   = max_q;
    stage_d = stage_q;
    nst_d   = nst_q;
    done_d  = 1'b0;
    case (state_q)
      StIdle: begin
        if (accept) begin
          max_d   = max_val;
          nst_d   = n_stages;
          idx_d   = '0;
          stage_d = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        if (ce) begin
          if (at_last) begin
            idx_d = '0;
            if (final_pass) begin
              stage_d = '0;
              state_d = StIdle;
              done_d  = 1'b1;
            end else begin
              stage_d = stage_q + STAGE_W'(1);
            end
          end else begin
            idx_d = idx_q + WIDTH'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      max_q   <= '0;
      stage_q <= '0;
      nst_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      max_q   <= max_d;
      stage_q <= stage_d;
      nst_q   <= nst_d;
      done_q  <= done_d;
    end
  end

  assign o_data  = idx_q;
  assign o_stage = stage_q;
  assign busy    = (state_q == StRun);
  assign over    = busy & at_last;
  assign done    = done_q;

`ifdef FFT_IDX_BITREV_EN
  localparam logic [RB_W-1:0] WidthRb = RB_W'(WIDTH);

  logic [RB_W-1:0]  rb_q, rb_d;
  logic [WIDTH-1:0] rev_full;

  // Clamp at latch time so the shift below never exceeds WIDTH.
  assign rb_d = accept ? ((rev_bits > WidthRb) ? WidthRb : rev_bits) : rb_q;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rb_q <= '0;
    end else begin
      rb_q <= rb_d;
    end
  end

  always_comb begin
    rev_full = '0;
    for (int i = 0; i < WIDTH; i++) begin
      rev_full[i] = idx_q[WIDTH-1-i];
    end
  end

  // Full reverse then right-shift keeps only the low rb_q bits, reversed.
  assign o_rev = rev_full >> (WidthRb - rb_q);
`else
  logic unused_rev_bits;
  assign unused_rev_bits = ^rev_bits;
  assign o_rev = idx_q;
`endif

endmodule
